swbut_sweep_driver: RTL and testbench
=====================================

SWBUT_SWEEP_DRIVER -- requirements
Module: swbut_sweep_driver

Interface
REQ-001 Parameter IN_W, default 15: switch operand width; display width.
REQ-002 Parameter DATA_W, default 27: kernel argument/result width; SHALL be >= IN_W.
REQ-003 Parameter DIV_W, default 27: auto-step prescale counter width; SHALL be >= IN_W + PS_SHIFT.
REQ-004 Parameter PS_SHIFT, default 12: prescale counter bits dropped before comparison with sw.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 nrst  input  1  reset, asynchronous assert, active-low.
REQ-007 sw  input  IN_W  operand (manual/hold) or step period (auto/sweep).
REQ-008 mode  input  2  0 manual, 1 auto-step, 2 sweep-max, 3 hold.
REQ-009 k_in_valid  output  1  argument valid to kernel.
REQ-010 k_in_ready  input  1  kernel accepts argument.
REQ-011 k_arg  output  DATA_W  kernel argument, zero-extended from IN_W.
REQ-012 k_out_valid  input  1  kernel result valid.
REQ-013 k_out_ready  output  1  driver accepts result.
REQ-014 k_res  input  DATA_W  kernel result.
REQ-015 disp  output  IN_W  displayed value: last result[IN_W-1:0] (modes 0, 1, 3) or best argument (mode 2).
REQ-016 busy  output  1  high while a request is outstanding (state != IDLE).

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and WAIT; at most one request SHALL be outstanding.
REQ-018 ISSUE: k_in_valid=1 and k_arg stable; ISSUE->WAIT on the cycle where k_in_valid & k_in_ready.
REQ-019 WAIT: k_out_ready=1; on k_out_valid, capture k_res and go to IDLE in the same edge.
REQ-020 k_out_ready SHALL be 0 outside WAIT.
REQ-021 k_in_valid SHALL be 0 outside ISSUE.
REQ-022 A result SHALL never be captured in the edge that accepts the argument.
REQ-023 Manual (mode 0), in IDLE: if zero-extended sw != arg, then arg<=sw and go to ISSUE; otherwise stay in IDLE.
REQ-024 Auto (mode 1) and sweep (mode 2), in IDLE:
  - div increments every cycle;
  - when div[DIV_W-1:PS_SHIFT]==sw: arg<=arg+1 (wraps mod 2^DATA_W), div<=0, go to ISSUE.
REQ-025 sw==0 in modes 1/2 SHALL issue every 2^PS_SHIFT cycles, never stall.
REQ-026 Hold (mode 3): no new issues; an in-flight request SHALL still complete.
REQ-027 div SHALL freeze outside IDLE and reset to 0 on any mode change.
REQ-028 Sweep: if captured k_res > best_res (unsigned), best_res<=k_res and best_arg<=arg; ties keep the older entry.
REQ-029 Entry into mode 2 from another mode SHALL clear best_res/best_arg and set arg<=0.
REQ-030 A mode change while in ISSUE or WAIT SHALL NOT abort the transaction; the new mode applies on return to IDLE.
REQ-031 Latency: sw change in mode 0 -> k_in_valid high at most 1 cycle later.
REQ-032 Latency: result capture -> disp update on the same edge.

Reset
REQ-033 While nrst is low: state=IDLE, k_in_valid=0, k_out_ready=0, arg=0, div=0, last result=0, best_res=0, best_arg=0, disp=0, busy=0.
REQ-034 Reset asserted mid-transaction SHALL discard the in-flight request; a late k_out_valid after release SHALL be ignored (IDLE).

Structure
REQ-035 Mode encodings and FSM state encodings SHALL live in a shared package (swbut_pkg).
REQ-036 The prescale counter and its compare SHALL be one sub-module, swbut_prescaler (ports: clk, nrst, clr, en, period, tick).
REQ-037 The kernel SHALL be instantiated outside this block; this block SHALL contain no kernel logic.

Verification
REQ-038 Manual: mode=0, sw=27, kernel model returns arg*3 after 5 cycles with k_in_ready=1 -> one request k_arg=27, disp=81, busy low afterwards.
REQ-039 Backpressure: k_in_ready held 0 for 10 cycles -> k_in_valid and k_arg stable throughout; exactly one transfer when ready rises.
REQ-040 Auto: mode=1, sw=1, PS_SHIFT=2 -> issue every 8 cycles plus handshake time; args 1, 2, 3.
REQ-041 Sweep: mode=2, model results 5, 9, 9, 3 for args 1..4 -> disp=2 (best_arg), best_res=9.
REQ-042 Wrap: DATA_W=4, arg=15 in auto mode -> next k_arg=0, no hang.
REQ-043 Reset in WAIT, then k_out_valid pulse after release -> ignored; state IDLE; disp=0.

Source files
------------

// File: rtl/swbut_pkg.sv
// Shared encodings for the switch/button sweep driver: operating modes,
// handshake FSM states and a small mode classification helper.
package swbut_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_SWEEP  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Modes whose argument advances on prescaler ticks rather than on sw.
    function automatic logic is_stepping(input mode_e m);
        return (m == MODE_AUTO) || (m == MODE_SWEEP);
    endfunction

endpackage

// File: rtl/swbut_prescaler.sv
// Auto-step prescaler: free-running up-counter with a period compare.
// tick marks the last cycle of a window of (period+1) * 2^PS_SHIFT enabled
// cycles, so period==0 still steps every 2^PS_SHIFT cycles instead of
// firing on the very first cycle after a clear.
module swbut_prescaler #(
    parameter int IN_W     = 15,
    parameter int DIV_W    = 27,
    parameter int PS_SHIFT = 12
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] period,
    output logic            tick
);

    localparam int HI_W = DIV_W - PS_SHIFT;
    localparam logic [PS_SHIFT-1:0] LOW_ONES = '1;

    logic [DIV_W-1:0] div_q, div_d;

    // Next count: clear wins over increment; frozen when not enabled.
    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q[DIV_W-1:PS_SHIFT] == HI_W'(period)) &&
                  (div_q[PS_SHIFT-1:0] == LOW_ONES);

endmodule

// File: rtl/swbut_sweep_driver.sv
// Drives one argument at a time into an external kernel over valid/ready,
// captures the result and shows it (or the best argument found while
// sweeping) on disp.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no request outstanding; mode changes are applied here
// ST_ISSUE | k_in_valid high, k_arg held until k_in_ready
// ST_WAIT  | k_out_ready high, waiting for k_out_valid to capture k_res
//
// The mode input is only adopted (amode_q) while idle, so a mode change
// never disturbs a transaction that is already in flight.
module swbut_sweep_driver
    import swbut_pkg::*;
#(
    parameter int IN_W     = 15,
    parameter int DATA_W   = 27,
    parameter int DIV_W    = 27,
    parameter int PS_SHIFT = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [IN_W-1:0]   sw,
    input  logic [1:0]        mode,
    output logic              k_in_valid,
    input  logic              k_in_ready,
    output logic [DATA_W-1:0] k_arg,
    input  logic              k_out_valid,
    output logic              k_out_ready,
    input  logic [DATA_W-1:0] k_res,
    output logic [IN_W-1:0]   disp,
    output logic              busy
);

    state_e            state_q, state_d;
    mode_e             amode_q, amode_d;
    mode_e             mode_in;
    logic [DATA_W-1:0] arg_q, arg_d;
    logic [IN_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0] best_res_q, best_res_d;
    logic [IN_W-1:0]   best_arg_q, best_arg_d;
    logic              ps_clr, ps_en, ps_tick;

    assign mode_in = mode_e'(mode);

    swbut_prescaler #(
        .IN_W    (IN_W),
        .DIV_W   (DIV_W),
        .PS_SHIFT(PS_SHIFT)
    ) u_prescaler (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (ps_clr),
        .en    (ps_en),
        .period(sw),
        .tick  (ps_tick)
    );

    // Next-state, argument stepping, result capture and sweep tracking.
    always_comb begin
        state_d    = state_q;
        amode_d    = amode_q;
        arg_d      = arg_q;
        last_d     = last_q;
        best_res_d = best_res_q;
        best_arg_d = best_arg_q;
        ps_clr     = 1'b0;
        ps_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode_in != amode_q) begin
                    amode_d = mode_in;
                    ps_clr  = 1'b1;
                    if (mode_in == MODE_SWEEP) begin
                        arg_d      = '0;
                        best_res_d = '0;
                        best_arg_d = '0;
                    end
                end else if (amode_q == MODE_MANUAL) begin
                    if (DATA_W'(sw) != arg_q) begin
                        arg_d   = DATA_W'(sw);
                        state_d = ST_ISSUE;
                    end
                end else if (is_stepping(amode_q)) begin
                    ps_en = 1'b1;
                    if (ps_tick) begin
                        arg_d   = arg_q + DATA_W'(1);
                        ps_clr  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (k_in_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (k_out_valid) begin
                    last_d = k_res[IN_W-1:0];
                    // Strictly greater: ties keep the earlier argument.
                    if ((amode_q == MODE_SWEEP) && (k_res > best_res_q)) begin
                        best_res_d = k_res;
                        best_arg_d = arg_q[IN_W-1:0];
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            amode_q    <= MODE_MANUAL;
            arg_q      <= '0;
            last_q     <= '0;
            best_res_q <= '0;
            best_arg_q <= '0;
        end else begin
            state_q    <= state_d;
            amode_q    <= amode_d;
            arg_q      <= arg_d;
            last_q     <= last_d;
            best_res_q <= best_res_d;
            best_arg_q <= best_arg_d;
        end
    end

    assign k_in_valid  = (state_q == ST_ISSUE);
    assign k_out_ready = (state_q == ST_WAIT);
    assign busy        = (state_q != ST_IDLE);
    assign k_arg       = arg_q;
    assign disp        = (amode_q == MODE_SWEEP) ? best_arg_q : last_q;

endmodule

// File: tb/tb_swbut_sweep_driver.sv
// Scoreboard bench for swbut_sweep_driver with a behavioural kernel.
module tb_swbut_sweep_driver;

    localparam int IN_W     = 8;
    localparam int DATA_W   = 10;
    localparam int DIV_W    = 10;
    localparam int PS_SHIFT = 2;
    localparam int ARG_MOD  = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [IN_W-1:0]   sw = '0;
    logic [1:0]        mode = 2'd0;
    logic              k_in_valid;
    logic              k_in_ready = 1'b0;
    logic [DATA_W-1:0] k_arg;
    logic              k_out_valid = 1'b0;
    logic              k_out_ready;
    logic [DATA_W-1:0] k_res = '0;
    logic [IN_W-1:0]   disp;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // reference model: what the driver should do, in plain arithmetic
    int unsigned m_arg = 0;
    int unsigned m_best_res = 0;
    int unsigned m_best_arg = 0;
    int          m_mode = 0;
    int unsigned exp_arg_q[$];
    logic [IN_W-1:0] exp_disp_q[$];

    // kernel behaviour controls
    int          res_kind = 0;
    int unsigned sweep_tab[$];
    int          lat = 5;
    bit          kauto = 1'b1;
    bit          kbusy = 1'b0;
    int          ready_kind = 1;

    // monitor state
    int issues = 0;
    int captures = 0;
    bit chk_gap = 1'b0;
    int exp_gap = 0;
    bit mon_pend = 1'b0;
    logic [DATA_W-1:0] mon_parg = '0;
    bit mon_cap = 1'b0;
    int idle_run = 0;

    logic [DATA_W-1:0] ka, kr;
    bit ksweep;
    int kn;

    always #5 clk = ~clk;

    swbut_sweep_driver #(
        .IN_W(IN_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .PS_SHIFT(PS_SHIFT)
    ) dut (
        .clk(clk), .nrst(nrst), .sw(sw), .mode(mode),
        .k_in_valid(k_in_valid), .k_in_ready(k_in_ready), .k_arg(k_arg),
        .k_out_valid(k_out_valid), .k_out_ready(k_out_ready), .k_res(k_res),
        .disp(disp), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] kernel_result(input logic [DATA_W-1:0] a);
        case (res_kind)
            0: return DATA_W'(a * 3);
            1: return (sweep_tab.size() > 0) ? DATA_W'(sweep_tab.pop_front()) : '0;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    // k_in_ready pattern
    initial forever begin
        @(posedge clk); #2;
        case (ready_kind)
            0: k_in_ready = 1'b0;
            1: k_in_ready = 1'b1;
            default: k_in_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // behavioural kernel; pushes the disp value the driver must show on capture
    initial forever begin
        @(negedge clk);
        if (kauto && nrst && k_in_valid && k_in_ready) begin
            kbusy = 1'b1;
            ka = k_arg;
            ksweep = (m_mode == 2);
            @(posedge clk);
            repeat (lat) @(posedge clk);
            #1;
            kr = kernel_result(ka);
            if (ksweep) begin
                if (kr > m_best_res) begin
                    m_best_res = kr;
                    m_best_arg = ka;
                end
                exp_disp_q.push_back(IN_W'(m_best_arg));
            end else begin
                exp_disp_q.push_back(kr[IN_W-1:0]);
            end
            k_res = kr;
            k_out_valid = 1'b1;
            kn = 0;
            do begin
                @(negedge clk);
                kn++;
            end while (!k_out_ready && kn < 200);
            if (!k_out_ready) begin
                total++; bad++;
                $display("FAIL kernel_result_accept: k_out_ready got 0 expected 1");
            end
            @(posedge clk); #1;
            k_out_valid = 1'b0;
            kbusy = 1'b0;
        end
    end

    // monitor: pops expectations whenever the DUT presents a transfer
    initial forever begin
        @(negedge clk);
        if (!nrst) begin
            mon_pend = 1'b0; mon_cap = 1'b0; idle_run = 0;
        end else begin
            if (mon_cap) begin
                mon_cap = 1'b0;
                if (exp_disp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL disp_capture: got %0d expected none queued", disp);
                end else begin
                    check("disp_capture", disp, exp_disp_q.pop_front());
                end
                check("busy_after_capture", busy, 0);
            end
            if (mon_pend) begin
                check("bp_valid_held", k_in_valid, 1);
                check("bp_arg_held", k_arg, mon_parg);
            end
            if (k_out_ready) check("no_valid_in_wait", k_in_valid, 0);
            if (k_in_valid && k_in_ready) begin
                issues++;
                if (exp_arg_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL issue_arg: got %0d expected no issue", k_arg);
                end else begin
                    check("issue_arg", k_arg, exp_arg_q.pop_front());
                end
            end
            mon_pend = k_in_valid && !k_in_ready;
            mon_parg = k_arg;
            if (k_out_valid && k_out_ready) begin
                mon_cap = 1'b1;
                captures++;
            end
            if (!busy) begin
                idle_run++;
            end else begin
                if (chk_gap && idle_run > 0) check("step_gap", idle_run, exp_gap);
                idle_run = 0;
            end
        end
    end

    task automatic wait_issues(input int target, input int budget, input string name);
        int n = 0;
        while (issues < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (issues < target) begin
            total++; bad++;
            $display("FAIL %s: issues got %0d expected %0d", name, issues, target);
        end
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((busy || kbusy || exp_arg_q.size() != 0 || exp_disp_q.size() != 0) && n < budget);
        if (busy || kbusy || exp_arg_q.size() != 0 || exp_disp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL %s: busy got %0d pending args %0d expected idle", name, busy, exp_arg_q.size());
        end
    endtask

    task automatic set_manual(input int v);
        bit exp_issue;
        @(posedge clk); #1;
        sw = IN_W'(v);
        exp_issue = (v != m_arg);
        if (exp_issue) begin
            m_arg = v;
            exp_arg_q.push_back(v);
        end
        @(posedge clk); @(negedge clk);
        check("manual_issue_latency", k_in_valid, exp_issue);
    endtask

    task automatic set_mode(input int md, input int s);
        @(posedge clk); #1;
        mode = md[1:0];
        sw = IN_W'(s);
        if (md == 2 && m_mode != 2) begin
            m_arg = 0; m_best_res = 0; m_best_arg = 0;
        end
        m_mode = md;
    endtask

    task automatic push_steps(input int n);
        for (int k = 0; k < n; k++) begin
            m_arg = (m_arg + 1) % ARG_MOD;
            exp_arg_q.push_back(m_arg);
        end
    endtask

    // run n stepped issues, checking the idle gap, then park in hold
    task automatic run_steps(input int md, input int s, input int n, input int budget);
        int i0;
        i0 = issues;
        set_mode(md, s);
        push_steps(n);
        exp_gap = (s + 1) << PS_SHIFT;
        wait_issues(i0 + 1, 200 + exp_gap * 4, "step_first");
        chk_gap = 1'b1;
        wait_issues(i0 + n, budget, "step_run");
        chk_gap = 1'b0;
        set_mode(3, s);
        wait_quiet(300, "step_quiet");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, c0, v;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_k_in_valid", k_in_valid, 0);
        check("rst_k_out_ready", k_out_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_disp", disp, 0);
        check("rst_k_arg", k_arg, 0);
        @(posedge clk); #1 nrst = 1'b1;
        repeat (3) @(posedge clk);

        // manual single request, result arg*3 after 5 cycles
        res_kind = 0; lat = 5; ready_kind = 1;
        set_manual(27);
        wait_quiet(100, "manual_quiet");
        check("manual_disp", disp, 81);
        check("manual_busy", busy, 0);

        // randomized manual traffic with random ready and latency
        ready_kind = 2;
        for (int i = 0; i < 12; i++) begin
            lat = $urandom_range(0, 6);
            v = (i == 5) ? int'(m_arg) : $urandom_range(0, 255);
            set_manual(v);
            wait_quiet(200, "rand_manual_quiet");
        end

        // backpressure: ready low for 10 cycles
        ready_kind = 0; lat = 2;
        @(posedge clk);
        i0 = issues;
        set_manual((m_arg == 200) ? 201 : 200);
        repeat (10) @(negedge clk);
        check("bp_no_transfer", issues, i0);
        ready_kind = 1;
        wait_quiet(100, "bp_quiet");
        check("bp_one_transfer", issues, i0 + 1);

        // auto-step from arg 0, sw=1: 8 idle cycles between requests
        set_manual(0);
        wait_quiet(100, "zero_quiet");
        run_steps(1, 1, 3, 400);
        check("auto_hold_disp", disp, 9);

        // hold issues nothing regardless of sw
        i0 = issues;
        @(posedge clk); #1 sw = 8'd77;
        repeat (40) @(negedge clk);
        check("hold_no_issue", issues, i0);

        // sweep with fixed results including ties
        res_kind = 1;
        sweep_tab = '{5, 9, 9, 3, 9, 10};
        c0 = captures;
        fork
            run_steps(2, 0, 6, 400);
            begin
                while (captures < c0 + 4) @(negedge clk);
                @(negedge clk); #1;
                check("sweep_best_arg", disp, 2);
            end
        join

        // randomized sweep
        res_kind = 2; ready_kind = 2;
        for (int r = 0; r < 2; r++) begin
            lat = $urandom_range(0, 4);
            run_steps(2, $urandom_range(0, 2), 8, 1000);
        end

        // auto wrap past the top of the argument range
        res_kind = 0; ready_kind = 1; lat = 0;
        run_steps(1, 0, ARG_MOD - int'(m_arg) + 2, 20000);
        check("wrap_last_arg", k_arg, m_arg);
        check("wrap_disp", disp, ((m_arg * 3) % ARG_MOD) & 8'hFF);

        // reset during WAIT, then a stray result after release
        kauto = 1'b0;
        i0 = issues;
        set_mode(0, 100);
        m_arg = 100;
        exp_arg_q.push_back(100);
        wait_issues(i0 + 1, 50, "rst_issue");
        @(posedge clk); #1;
        check("rst_in_wait", k_out_ready, 1);
        nrst = 1'b0; sw = '0;
        m_arg = 0; m_best_res = 0; m_best_arg = 0;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_k_out_ready", k_out_ready, 0);
        check("rst_async_disp", disp, 0);
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;
        k_res = 10'd77; k_out_valid = 1'b1;
        @(posedge clk); #1;
        k_out_valid = 1'b0;
        @(negedge clk);
        check("late_result_busy", busy, 0);
        check("late_result_disp", disp, 0);
        check("late_result_k_in_valid", k_in_valid, 0);
        repeat (5) @(negedge clk);
        check("late_result_no_issue", issues, i0 + 1);

        check("arg_queue_empty", exp_arg_q.size(), 0);
        check("disp_queue_empty", exp_disp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
